// File: rtl/bin_erode_pkg.sv
// Shared constants and types for the binary 3x3 erosion block and its line buffers.
package bin_erode_pkg;

  localparam int unsigned      DEF_IMG_WIDTH = 640;
  localparam logic [7:0]       DEF_THRESH    = 8'd128;
  localparam int unsigned      PIPE_LAT      = 3;
  localparam int unsigned      ROW_W         = 10;
  localparam logic [ROW_W-1:0] ROW_MAX       = 10'd1023;

  // Per-pixel control that travels alongside the data through the pipeline
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ok;    // column inside the line buffers
    logic cge1;  // column >= 1: left tap is real image
    logic cge2;  // column >= 2: second-left tap is real image
  } tap_ctl_t;

  function automatic logic binarize(input logic [7:0] pix, input logic [7:0] thr);
    return (pix >= thr);
  endfunction

endpackage

// File: rtl/erode_linebuf.sv
// One line of 1-bit pixels: simple dual-port, synchronous read, read-before-write.
module erode_linebuf
  import bin_erode_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_IMG_WIDTH,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          pclk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);

  logic mem_q [DEPTH];
  logic rd_q;

  // Storage write and registered read; a same-address read returns the old bit
  always_ff @(posedge pclk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/bin_erode.sv
// Binary 3x3 erosion of a streamed grayscale image: threshold, two 1-bit line
// buffers for the rows above, then a three-tap horizontal AND. Latency 3 cycles.
module bin_erode
  import bin_erode_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = DEF_IMG_WIDTH,
  parameter logic [7:0]  THRESH    = DEF_THRESH
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       gray_hs,
  input  logic       gray_vs,
  input  logic       gray_de,
  input  logic [7:0] gray_din,
  output logic       erode_hs,
  output logic       erode_vs,
  output logic       erode_de,
  output logic       erode_dout
);

  localparam int unsigned      AW      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned      CW      = $clog2(IMG_WIDTH + 1);
  localparam logic [CW-1:0]    COL_LIM = CW'(IMG_WIDTH);
  localparam logic [CW-1:0]    COL_ONE = CW'(1);
  localparam logic [CW-1:0]    COL_TWO = CW'(2);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  logic             armed_q, armed_d;
  logic             de_prev_q, de_prev_d;
  logic             vs_prev_q, vs_prev_d;
  logic [CW-1:0]    col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic             de_in_s, vs_rise_s, in_line_s, b_s;
  logic [ROW_W-1:0] row_cur_s;
  logic [AW-1:0]    addr_s;
  logic             lb1_we_s, lb2_we_s, lb1_rd_s, lb2_rd_s;
  logic             v_s, dout_s;

  tap_ctl_t         s1_q, s1_d, s2_q, s2_d;
  logic             b1_q, b1_d, rge1_q, rge1_d, rge2_q, rge2_d;
  logic [AW-1:0]    addr1_q, addr1_d;
  logic             v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic             erode_hs_q, erode_hs_d, erode_vs_q, erode_vs_d;
  logic             erode_de_q, erode_de_d, erode_dout_q, erode_dout_d;

  // Input stage: counters, binarization and line-buffer addressing
  always_comb begin
    // armed drops on a mid-line reset so the rest of that line is ignored
    de_in_s   = gray_de & armed_q;
    vs_rise_s = gray_vs & ~vs_prev_q;
    in_line_s = (col_q < COL_LIM);
    row_cur_s = vs_rise_s ? '0 : row_q;
    addr_s    = in_line_s ? AW'(col_q) : '0;
    b_s       = binarize(gray_din, THRESH);
    lb1_we_s  = de_in_s & in_line_s;

    armed_d   = armed_q | ~gray_de;
    de_prev_d = de_in_s;
    vs_prev_d = gray_vs;

    if (!de_in_s) begin
      col_d = '0;
    end else if (in_line_s) begin
      col_d = col_q + COL_ONE;
    end else begin
      col_d = col_q;
    end

    if (vs_rise_s) begin
      row_d = '0;
    end else if (de_prev_q && !de_in_s && (row_q != ROW_MAX)) begin
      row_d = row_q + ROW_ONE;
    end else begin
      row_d = row_q;
    end

    s1_d.hs   = gray_hs;
    s1_d.vs   = gray_vs;
    s1_d.de   = de_in_s;
    s1_d.ok   = in_line_s;
    s1_d.cge1 = (col_q >= COL_ONE);
    s1_d.cge2 = (col_q >= COL_TWO);
    b1_d      = b_s;
    rge1_d    = (row_cur_s >= ROW_ONE);
    rge2_d    = (row_cur_s > ROW_ONE);
    addr1_d   = addr_s;
  end

  // Vertical AND with row padding, then horizontal AND with column padding
  always_comb begin
    v_s      = b1_q & (rge1_q ? lb1_rd_s : 1'b1) & (rge2_q ? lb2_rd_s : 1'b1);
    lb2_we_s = s1_q.de & s1_q.ok;
    s2_d     = s1_q;
    v2_d     = v_s;
    v3_d     = v2_q;
    v4_d     = v3_q;
    dout_s   = s2_q.de & s2_q.ok & v2_q
             & (s2_q.cge1 ? v3_q : 1'b1) & (s2_q.cge2 ? v4_q : 1'b1);

    erode_hs_d   = s2_q.hs;
    erode_vs_d   = s2_q.vs;
    erode_de_d   = s2_q.de;
    erode_dout_d = dout_s;
  end

  // All counters, tap and sync pipelines; line-buffer storage is never reset
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      armed_q      <= 1'b0;
      de_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      b1_q         <= 1'b0;
      rge1_q       <= 1'b0;
      rge2_q       <= 1'b0;
      addr1_q      <= '0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      v4_q         <= 1'b0;
      erode_hs_q   <= 1'b0;
      erode_vs_q   <= 1'b0;
      erode_de_q   <= 1'b0;
      erode_dout_q <= 1'b0;
    end else begin
      armed_q      <= armed_d;
      de_prev_q    <= de_prev_d;
      vs_prev_q    <= vs_prev_d;
      col_q        <= col_d;
      row_q        <= row_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      b1_q         <= b1_d;
      rge1_q       <= rge1_d;
      rge2_q       <= rge2_d;
      addr1_q      <= addr1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      v4_q         <= v4_d;
      erode_hs_q   <= erode_hs_d;
      erode_vs_q   <= erode_vs_d;
      erode_de_q   <= erode_de_d;
      erode_dout_q <= erode_dout_d;
    end
  end

  // lb1 holds the previous row; lb2 is refilled from lb1 one cycle later
  erode_linebuf #(.DEPTH(IMG_WIDTH), .AW(AW)) u_lb1 (
    .pclk    (pclk),
    .wr_en   (lb1_we_s),
    .wr_addr (addr_s),
    .wr_data (b_s),
    .rd_addr (addr_s),
    .rd_data (lb1_rd_s)
  );

  erode_linebuf #(.DEPTH(IMG_WIDTH), .AW(AW)) u_lb2 (
    .pclk    (pclk),
    .wr_en   (lb2_we_s),
    .wr_addr (addr1_q),
    .wr_data (lb1_rd_s),
    .rd_addr (addr_s),
    .rd_data (lb2_rd_s)
  );

  assign erode_hs   = erode_hs_q;
  assign erode_vs   = erode_vs_q;
  assign erode_de   = erode_de_q;
  assign erode_dout = erode_dout_q;

endmodule
